// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// the shadow register-destination entry and a small match helper.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } forward_type;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       reg_write;
    logic       mem_read;
  } hazard_entry_type;

  localparam hazard_entry_type BUBBLE_ENTRY = '0;

  // True when entry e will write architectural register idx (x0 never counts)
  function automatic logic writes_reg(hazard_entry_type e, logic [4:0] idx);
    return e.valid & e.reg_write & (e.rd != 5'd0) & (e.rd == idx);
  endfunction

endpackage

// File: rtl/hazard_unit_forward_select.sv
// Picks the ALU operand source for one EX operand: the MEM-stage result,
// the WB-stage result, or the register file value.
module forward_select
  import hazard_unit_pkg::*;
(
  input  logic [4:0]       src,
  input  logic             uses,
  input  hazard_entry_type mem_q,
  input  hazard_entry_type wb_q,
  output forward_type      sel
);

  // Only the destination fields of MEM/WB matter here; the rest is folded away
  logic unused_fields;
  assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.uses_rs1, mem_q.uses_rs2,
                           wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2,
                           wb_q.mem_read};

  // Youngest producer wins; a load in MEM has no data yet so it is skipped
  always_comb begin
    sel = FWD_NONE;
    if (uses) begin
      if (writes_reg(mem_q, src) && !mem_q.mem_read) begin
        sel = FWD_MEM;
      end else if (writes_reg(wb_q, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core: tracks EX/MEM/WB
// destinations and produces stall, flush, bubble and forwarding controls.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       ex_branch_taken,
  input  logic       ext_stall,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_if,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       freeze,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  hazard_entry_type ex_q, mem_q, wb_q;
  hazard_entry_type id_entry;
  forward_type      fwd_a_sel, fwd_b_sel;
  logic             load_use;
  logic             issue;

  assign id_entry = '{valid:     1'b1,
                      rd:        id_rd,
                      rs1:       id_rs1,
                      rs2:       id_rs2,
                      uses_rs1:  id_uses_rs1,
                      uses_rs2:  id_uses_rs2,
                      reg_write: id_reg_write,
                      mem_read:  id_mem_read};

  assign load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_q.rd)));

  assign issue = id_valid & !load_use & !ex_branch_taken;

  // Shadow pipeline: advances with the datapath, holds while memory stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= BUBBLE_ENTRY;
      mem_q <= BUBBLE_ENTRY;
      wb_q  <= BUBBLE_ENTRY;
    end else if (!ext_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= issue ? id_entry : BUBBLE_ENTRY;
    end
  end

  forward_select u_fwd_a (
    .src   (ex_q.rs1),
    .uses  (ex_q.valid & ex_q.uses_rs1),
    .mem_q (mem_q),
    .wb_q  (wb_q),
    .sel   (fwd_a_sel)
  );

  forward_select u_fwd_b (
    .src   (ex_q.rs2),
    .uses  (ex_q.valid & ex_q.uses_rs2),
    .mem_q (mem_q),
    .wb_q  (wb_q),
    .sel   (fwd_b_sel)
  );

  // Prioritised control outputs; everything is quiet while reset is held
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    fwd_a     = FWD_NONE;
    fwd_b     = FWD_NONE;
    if (rst) begin
      fwd_a = fwd_a_sel;
      fwd_b = fwd_b_sel;
      if (ext_stall) begin
        freeze = 1'b1;
      end else if (ex_branch_taken) begin
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: each cycle's stimulus pushes the
// expected control vector to a scoreboard that is checked on the falling edge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       ext_stall = 1'b0;
  logic       stall_if, stall_id, flush_if, flush_id, bubble_ex, freeze;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp_v;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t cur_item;

  // Control word {rst, ex_branch_taken, ext_stall}
  localparam logic [2:0] C_RUN = 3'b100;
  localparam logic [2:0] C_BR  = 3'b110;
  localparam logic [2:0] C_ES  = 3'b101;
  localparam logic [2:0] C_RST = 3'b000;
  localparam logic [2:0] C_RST_ALL = 3'b011;

  // Expected {freeze, stall_if, stall_id, flush_if, flush_id, bubble_ex, fwd_a, fwd_b}
  localparam logic [9:0] E_NONE = 10'b0_00_00_0_00_00;
  localparam logic [9:0] E_LU   = 10'b0_11_00_1_00_00;
  localparam logic [9:0] E_BR   = 10'b0_00_11_1_00_00;
  localparam logic [9:0] E_FRZ  = 10'b1_00_00_0_00_00;
  localparam logic [9:0] E_WN   = 10'b0_00_00_0_10_00;
  localparam logic [9:0] E_NW   = 10'b0_00_00_0_00_10;
  localparam logic [9:0] E_MM   = 10'b0_00_00_0_01_01;
  localparam logic [9:0] E_WW   = 10'b0_00_00_0_10_10;

  hazard_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ext_stall       (ext_stall),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush_if        (flush_if),
    .flush_id        (flush_id),
    .bubble_ex       (bubble_ex),
    .freeze          (freeze),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [9:0] observed,
                             input logic [9:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (frz,sif,sid,fif,fid,bub,fa,fb)",
               tag, observed, expected);
    end
  endtask

  // Drive one cycle of ID/EX inputs just after the rising edge and queue its expectation
  task automatic applyStimulus(input string tag, input logic [2:0] ctl, input logic v,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic u1, input logic [4:0] rs2, input logic u2,
                               input logic rw, input logic mr, input logic [9:0] exp_v);
    @(posedge clk);
    #1;
    rst             = ctl[2];
    ex_branch_taken = ctl[1];
    ext_stall       = ctl[0];
    id_valid        = v;
    id_rd           = rd;
    id_rs1          = rs1;
    id_uses_rs1     = u1;
    id_rs2          = rs2;
    id_uses_rs2     = u2;
    id_reg_write    = rw;
    id_mem_read     = mr;
    sb_q.push_back('{tag, exp_v});
  endtask

  // Compare the combinational outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur_item = sb_q.pop_front();
      checkOutput(cur_item.tag,
                  {freeze, stall_if, stall_id, flush_if, flush_id, bubble_ex, fwd_a, fwd_b},
                  cur_item.exp_v);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] hazard_unit bench starting");
    //                tag            ctl        v  rd  rs1 u1 rs2 u2 rw mr  expected
    applyStimulus("reset0",        C_RST,     0, 0,  0,  0, 0,  0, 0, 0, E_NONE);
    applyStimulus("reset1",        C_RST,     0, 0,  0,  0, 0,  0, 0, 0, E_NONE);
    // lw x5 ; add x6,x5,x1
    applyStimulus("lu_lw",         C_RUN,     1, 5,  1,  1, 0,  0, 1, 1, E_NONE);
    applyStimulus("lu_stall",      C_RUN,     1, 6,  5,  1, 1,  1, 1, 0, E_LU);
    applyStimulus("lu_reissue",    C_RUN,     1, 6,  5,  1, 1,  1, 1, 0, E_NONE);
    applyStimulus("lu_fwd_wb",     C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_WN);
    // addi x5,x0,3 ; sub x7,x5,x5 ; or x8,x5,x0
    applyStimulus("alu_addi",      C_RUN,     1, 5,  0,  1, 0,  0, 1, 0, E_NONE);
    applyStimulus("alu_sub",       C_RUN,     1, 7,  5,  1, 5,  1, 1, 0, E_NONE);
    applyStimulus("alu_fwd_mem",   C_RUN,     1, 8,  5,  1, 0,  1, 1, 0, E_MM);
    applyStimulus("alu_fwd_wb",    C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_WN);
    // addi x0,x0,1 ; add x2,x0,x0 ; lw x0 ; add x3,x0,x0
    applyStimulus("x0_addi",       C_RUN,     1, 0,  0,  1, 0,  0, 1, 0, E_NONE);
    applyStimulus("x0_add",        C_RUN,     1, 2,  0,  1, 0,  1, 1, 0, E_NONE);
    applyStimulus("x0_lw",         C_RUN,     1, 0,  1,  1, 0,  0, 1, 1, E_NONE);
    applyStimulus("x0_no_stall",   C_RUN,     1, 3,  0,  1, 0,  1, 1, 0, E_NONE);
    applyStimulus("x0_no_fwd",     C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_NONE);
    // lw x9 ; branch taken with add x10,x9,x9 in ID ; or x11,x10 must not see x10
    applyStimulus("br_lw",         C_RUN,     1, 9,  2,  1, 0,  0, 1, 1, E_NONE);
    applyStimulus("br_flush",      C_BR,      1, 10, 9,  1, 9,  1, 1, 0, E_BR);
    applyStimulus("br_after",      C_RUN,     1, 11, 10, 1, 0,  0, 1, 0, E_NONE);
    applyStimulus("br_killed",     C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_NONE);
    // lw x12 ; ext_stall for 3 cycles with add x13,x12,x12 in ID
    applyStimulus("es_lw",         C_RUN,     1, 12, 1,  1, 0,  0, 1, 1, E_NONE);
    applyStimulus("es_freeze0",    C_ES,      1, 13, 12, 1, 12, 1, 1, 0, E_FRZ);
    applyStimulus("es_freeze1",    C_ES,      1, 13, 12, 1, 12, 1, 1, 0, E_FRZ);
    applyStimulus("es_freeze2",    C_ES,      1, 13, 12, 1, 12, 1, 1, 0, E_FRZ);
    applyStimulus("es_lu_stall",   C_RUN,     1, 13, 12, 1, 12, 1, 1, 0, E_LU);
    applyStimulus("es_one_stall",  C_RUN,     1, 13, 12, 1, 12, 1, 1, 0, E_NONE);
    applyStimulus("es_fwd_wb",     C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_WW);
    // fill EX/MEM/WB then reset mid-stream
    applyStimulus("rs_addi",       C_RUN,     1, 14, 0,  1, 0,  0, 1, 0, E_NONE);
    applyStimulus("rs_add",        C_RUN,     1, 15, 14, 1, 14, 1, 1, 0, E_NONE);
    applyStimulus("rs_lw",         C_RUN,     1, 16, 15, 1, 0,  0, 1, 1, E_MM);
    applyStimulus("rs_low",        C_RST,     1, 17, 16, 1, 16, 1, 1, 0, E_NONE);
    applyStimulus("rs_low_all",    C_RST_ALL, 1, 17, 16, 1, 16, 1, 1, 0, E_NONE);
    applyStimulus("rs_issue",      C_RUN,     1, 17, 16, 1, 16, 1, 1, 0, E_NONE);
    applyStimulus("rs_no_fwd",     C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_NONE);
    // operand b only, and an unused rs2 match must not stall
    applyStimulus("b_lw",          C_RUN,     1, 20, 1,  1, 0,  0, 1, 1, E_NONE);
    applyStimulus("b_unused_rs2",  C_RUN,     1, 0,  1,  1, 20, 0, 0, 0, E_NONE);
    applyStimulus("b_add",         C_RUN,     1, 21, 1,  1, 20, 1, 1, 0, E_NONE);
    applyStimulus("b_fwd_wb",      C_RUN,     0, 0,  0,  0, 0,  0, 0, 0, E_NW);
    // a matching index with id_valid low is not a load-use hazard
    applyStimulus("v_lw",          C_RUN,     1, 22, 1,  1, 0,  0, 1, 1, E_NONE);
    applyStimulus("v_invalid_id",  C_RUN,     0, 0,  22, 1, 22, 1, 0, 0, E_NONE);

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", 10'(sb_q.size()), 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RV32I core (IF, ID, EX, MEM, WB). It keeps a shadow copy of the register-destination information for the EX, MEM and WB stages. From that state it produces the stall, flush and operand-forwarding controls the datapath needs around the decoder and ALU. It sits beside the `control` decoder in ID and takes its inputs from ID-stage fields and the EX-stage branch outcome.

## Interface
- No parameters. The register index width is fixed at 5 bits, and x0 is hard-wired zero.
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`  in  5 each  ID source register indices
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction reads rs1 / rs2
- `id_rd`  in  5  ID destination index
- `id_reg_write`  in  1  the ID instruction writes rd (from `control.RegWrite`)
- `id_mem_read`  in  1  the ID instruction is a load
- `ex_branch_taken`  in  1  the EX branch/jump resolves as taken
- `ext_stall`  in  1  memory not ready; freezes the whole pipeline
- `stall_if`, `stall_id`  out  1 each  hold PC / hold the IF/ID register
- `flush_if`, `flush_id`  out  1 each  kill the instruction in IF / ID
- `bubble_ex`  out  1  insert a NOP into ID/EX
- `freeze`  out  1  hold every pipeline register (mirrors `ext_stall`)
- `fwd_a`, `fwd_b`  out  2 each  ALU operand source select for the EX instruction: `forward_type`

## Operation
- Shadow entries `ex_q`, `mem_q`, `wb_q`, each of type `hazard_entry_type`: {valid, rd, rs1, rs2, uses_rs1, uses_rs2, reg_write, mem_read}.
- Per edge, when `rst`=1 and `ext_stall`=0:
  - `wb_q` ← `mem_q`
  - `mem_q` ← `ex_q`
  - `ex_q` ← the ID entry if `issue`, otherwise an invalid bubble
- `issue` = `id_valid` & !`load_use` & !`ex_branch_taken`.
- `load_use` = `ex_q`.valid & `ex_q`.mem_read & `ex_q`.rd≠0 & ((`id_uses_rs1` & `id_rs1`==`ex_q`.rd) | (`id_uses_rs2` & `id_rs2`==`ex_q`.rd)). It is qualified by `id_valid`.
- Priority, highest first:
  1. `ext_stall`: `freeze`=1, all shadow regs hold, all other stall/flush/bubble outputs 0.
  2. `ex_branch_taken`: `flush_if`=`flush_id`=`bubble_ex`=1, stalls 0. A simultaneous load-use stall is discarded.
  3. `load_use`: `stall_if`=`stall_id`=`bubble_ex`=1.
  4. Otherwise all 0.
- Forwarding for operand a (operand b is identical, using rs2 / uses_rs2):
  - `FWD_MEM` if `mem_q`.valid & reg_write & !mem_read & rd≠0 & rd==`ex_q`.rs1 & `ex_q`.uses_rs1.
  - Else `FWD_WB` if `wb_q` matches under the same rule, with a load allowed.
  - Else `FWD_NONE`.
  - MEM has priority over WB.
  - `fwd_*` is `FWD_NONE` whenever `ex_q`.valid=0.
- A load in MEM is never a forwarding source. This is guaranteed by the `load_use` stall.
- Register-file write/read in the same cycle (WB to ID) is bypassed by the register file, not by this block.

## Timing
- All outputs are combinational from the current shadow state and the ID/EX inputs. There are no output registers and there is zero-cycle latency.
- A load-use hazard costs exactly one stall cycle. On the next edge the load moves to MEM, `load_use` drops, and the consumer issues with `fwd_*`=`FWD_WB` one cycle later.
- A taken branch costs two killed slots (IF, ID). The branch itself proceeds to MEM.
- During `ext_stall`, the datapath holds `ex_branch_taken` stable. Flush takes effect in the first cycle after `ext_stall` drops.
- Reset (`rst`=0 at an edge): all shadow valids are cleared.
  - While `rst`=0, all outputs are forced to 0 and `fwd_*`=`FWD_NONE`.
  - Reset asserted mid-stall or mid-flush discards the pending action.

## Structure
- Add to `common`:
  - `forward_type` enum: `FWD_NONE`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10
  - `hazard_entry_type` packed struct
- One sub-module, `forward_select`, instantiated twice (operand a, operand b). Inputs: `ex_q` source index and use flag, `mem_q`, `wb_q`. Output: `forward_type`.

## Test plan
- Load then dependent op: `lw x5`, then `add x6,x5,x1`. Expect one cycle of `stall_if`=`stall_id`=`bubble_ex`=1, then the `add` in EX with `fwd_a`=`FWD_WB`, `fwd_b`=`FWD_NONE`.
- Back-to-back ALU ops: `addi x5,x0,3`, then `sub x7,x5,x5`. Expect no stall and `fwd_a`=`fwd_b`=`FWD_MEM`. A third op `or x8,x5,x0` gets `fwd_a`=`FWD_WB`.
- Writes to x0: `addi x0,x0,1`, then `add x2,x0,x0`. Expect `fwd_a`=`fwd_b`=`FWD_NONE`. `lw x0` followed by a use causes no stall.
- Branch taken while a load-use is pending in the same cycle: expect `flush_if`=`flush_id`=`bubble_ex`=1, `stall_*`=0, and the ID instruction never reaches EX.
- `ext_stall` held for 3 cycles with a load in EX and a dependent op in ID: expect `freeze`=1, `stall_*`=0, shadow state unchanged. After release, exactly one load-use stall cycle follows.
- `rst`=0 asserted mid-stream with valid entries in EX/MEM/WB: expect all outputs 0 while low. After release, an independent ID instruction issues with no stall and no forwarding.
